seq_detector_param: RTL



---
 rtl/seq_detector_param.sv | 117 +++++++++++
 1 files changed

// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - parametrised Moore serial-pattern detector with saturating match counter
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   synchronous, active-high reset
//   x        in   serial data bit
//   valid    in   x is sampled only when high
//   load     in   capture pat/len/ovl this cycle (a valid bit in the same cycle is dropped)
//   pat      in   new pattern, right-aligned; pat[len-1] is the first bit expected
//   len      in   new pattern length (0 -> 1, above MAXLEN -> MAXLEN)
//   ovl      in   new overlap mode (1 = overlapping matches allowed)
//   y        out  registered match flag, holds until the next valid bit, load or reset
//   count    out  saturating number of matches since reset/load
//   cnt_sat  out  count is all-ones
module seq_detector_param #(
  parameter int                MAXLEN  = 8,
  parameter int                LENW    = 4,
  parameter int                CNTW    = 8,
  parameter logic [MAXLEN-1:0] DEF_PAT = MAXLEN'(4'b1010),
  parameter int                DEF_LEN = 4,
  parameter logic              DEF_OVL = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              x,
  input  logic              valid,
  input  logic              load,
  input  logic [MAXLEN-1:0] pat,
  input  logic [LENW-1:0]   len,
  input  logic              ovl,
  output logic              y,
  output logic [CNTW-1:0]   count,
  output logic              cnt_sat
);

  logic [MAXLEN-1:0] p_q, p_d;
  logic [LENW-1:0]   l_q, l_d;
  logic              o_q, o_d;
  logic [MAXLEN-1:0] h_q, h_d;
  logic [LENW-1:0]   f_q, f_d;
  logic              y_q, y_d;
  logic [CNTW-1:0]   count_q, count_d;

  logic [MAXLEN-1:0] h_n;
  logic [MAXLEN-1:0] mask;
  logic [LENW-1:0]   f_n;
  logic              match;

  always_comb begin
    p_d     = p_q;
    l_d     = l_q;
    o_d     = o_q;
    h_d     = h_q;
    f_d     = f_q;
    y_d     = y_q;
    count_d = count_q;

    h_n = {h_q[MAXLEN-2:0], x};
    // Fill count saturates at MAXLEN; it only has to prove L real bits have arrived.
    f_n = (f_q >= LENW'(MAXLEN)) ? f_q : f_q + LENW'(1);

    // Only the low L bits of history and pattern take part in the compare.
    for (int i = 0; i < MAXLEN; i++) begin
      mask[i] = (LENW'(i) < l_q);
    end
    match = (f_n >= l_q) && (((h_n ^ p_q) & mask) == '0);

    if (load) begin
      p_d = pat;
      o_d = ovl;
      if (len == '0) begin
        l_d = LENW'(1);
      end else if (len > LENW'(MAXLEN)) begin
        l_d = LENW'(MAXLEN);
      end else begin
        l_d = len;
      end
      h_d     = '0;
      f_d     = '0;
      y_d     = 1'b0;
      count_d = '0;
    end else if (valid) begin
      h_d = h_n;
      y_d = match;
      // Non-overlap: emptying the fill count forces L fresh bits before the next match.
      f_d = (match && !o_q) ? '0 : f_n;
      if (match && !(&count_q)) begin
        count_d = count_q + CNTW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p_q     <= DEF_PAT;
      l_q     <= LENW'(DEF_LEN);
      o_q     <= DEF_OVL;
      h_q     <= '0;
      f_q     <= '0;
      y_q     <= 1'b0;
      count_q <= '0;
    end else begin
      p_q     <= p_d;
      l_q     <= l_d;
      o_q     <= o_d;
      h_q     <= h_d;
      f_q     <= f_d;
      y_q     <= y_d;
      count_q <= count_d;
    end
  end

  assign y       = y_q;
  assign count   = count_q;
  assign cnt_sat = &count_q;

endmodule
